writeback_arbiter: RTL and testbench
====================================

# writeback_arbiter

Writeback-side companion of the 8 x 16-bit register file. It accepts results from two producers: the single-cycle ALU path and the multi-cycle load path. Each result is buffered in a one-entry slot, and the arbiter issues at most one write per cycle on the register file's `we`/`ws`/`wd` write port. It also keeps a pending-load scoreboard (`busy`) that decode uses to stall on registers whose load has not yet been written back.

## Interface
Parameters:
- `DATA_W`, 16: data width of a register and of a result.
- `ADDR_W`, 3: register address width (8 registers).
- `STREAK_MAX`, 3: maximum consecutive load grants while an ALU result is waiting.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `alu_valid`, in, 1: ALU result offered.
- `alu_ready`, out, 1: ALU slot can accept.
- `alu_rd`, in, ADDR_W: ALU destination register.
- `alu_data`, in, DATA_W: ALU result.
- `mem_valid`, in, 1: load result offered.
- `mem_ready`, out, 1: load slot can accept.
- `mem_rd`, in, ADDR_W: load destination register.
- `mem_data`, in, DATA_W: load data.
- `issue_valid`, in, 1: decode has issued a load this cycle.
- `issue_rd`, in, ADDR_W: destination register of that load.
- `busy`, out, 8: one bit per register, set while a load to that register is outstanding.
- `we`, out, 1: register-file write enable.
- `ws`, out, ADDR_W: write select.
- `wd`, out, DATA_W: write data.

## Operation
- Each source has a one-entry slot with fields `v`, `rd`, `data`.
- A transfer happens when `*_valid && *_ready`. The slot loads at that edge.
- `*_ready = !slot.v || slot_granted_this_cycle`. Back-to-back transfers are therefore possible at full throughput.
- Arbitration runs each cycle over the two slots:
  - Only one slot valid: grant it.
  - Both valid: grant mem unless `streak == STREAK_MAX`, in which case grant ALU.
- `streak` (2-bit counter):
  - Increments on a mem grant while the ALU slot is valid.
  - Clears on an ALU grant, or in any cycle where the ALU slot is empty.
  - Saturates at STREAK_MAX.
- Granted slot drives the write port: `we=1`, `ws=slot.rd`, `wd=slot.data`. The slot's `v` clears at the edge unless a new transfer refills it in the same cycle.
- No grant: `we=0`. `ws` and `wd` hold their last value. Every register, r0 included, is writable.
- Scoreboard:
  - `issue_valid` sets `busy[issue_rd]`.
  - A mem grant clears `busy[ws]`.
  - Set and clear of the same bit in the same cycle: set wins.
- Decode contract:
  - Decode does not issue to a register whose busy bit is set.
  - Decode stalls any instruction that reads or writes a busy register.
  - The block does not check this contract. The bench asserts it.

## Timing
- Reset (asynchronous, `rst_n=0`):
  - Both slots empty; `streak=0`; `busy=8'h00`.
  - `we=0`, `ws=0`, `wd=0`.
  - `alu_ready=1` and `mem_ready=1` once `rst_n` is high.
- Latency: a transfer in cycle N gives `we=1` in cycle N+1 if granted. The register file updates at the edge closing N+1.
- Throughput: one write per cycle total. Sustained dual-source traffic splits roughly 3:1 mem:ALU.
- `we`, `ws` and `wd` are combinational from slot state only, never from the current inputs.
- Reset asserted mid-operation: slot contents and busy bits are discarded and no write is issued. Outstanding loads must be replayed by the pipeline.
- `issue_valid` and a mem grant for a different register in the same cycle: both updates take effect.

## Structure
- Shared package `riscv_pkg` holds:
  - `DATA_W`, `ADDR_W`, `NUM_REGS=8`, `STREAK_MAX`.
  - Typedef `wb_slot_t {v, rd, data}`.
- Sub-module `wb_hold_slot`: the one-entry slot with its handshake (`in_valid`, `in_ready`, `grant`). It is instantiated twice, once per source.
- Arbiter, streak counter and scoreboard sit in the top module.

## Test plan
- Reset, then ALU sends r3=16'h1234 with `mem_valid=0` -> cycle N+1: `we=1`, `ws=3`, `wd=16'h1234`. Register file reads r3=16'h1234 afterwards.
- `issue_valid` with r5, then 4 idle cycles, then mem returns r5=16'hBEEF -> `busy[5]=1` until the edge after the mem grant, then `busy=8'h00`. Write issued with `wd=16'hBEEF`.
- Both sources valid every cycle for 8 cycles -> grant order mem,mem,mem,alu,mem,mem,mem,alu. `we=1` every cycle and no data lost.
- Same cycle: `issue_valid` r2 and mem grant to r2 -> `busy[2]` remains 1.
- ALU slot full with r1=16'h0001; `rst_n` pulsed low asynchronously mid-cycle -> `we=0` immediately, `busy=0`. After release, both readys are 1 and no write to r1 occurs.
- ALU streams r0..r7 with data=16'h00A0+i on consecutive cycles -> 8 consecutive writes, `alu_ready` never deasserts.

Source files
------------

// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Shared widths and the writeback slot record used by the
//               register file and writeback arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    localparam int DATA_W     = 16;
    localparam int ADDR_W     = 3;
    localparam int NUM_REGS   = 8;
    localparam int STREAK_MAX = 3;

    // One buffered writeback result: valid flag, destination, payload.
    typedef struct packed {
        logic              v;
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_slot_t;

endpackage : riscv_pkg
`default_nettype wire

// File: rtl/wb_hold_slot.sv
`default_nettype none
// ============================================================================
// Module      : wb_hold_slot
// Description : One-entry result buffer with valid/ready handshake. The slot
//               accepts a new result whenever it is empty or is being drained
//               by a grant in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_hold_slot
    import riscv_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic [DATA_W-1:0] in_data,
    input  logic              grant,
    output wb_slot_t          slot
);

    wb_slot_t r_slot;

    // Draining and refilling in the same cycle keeps full throughput.
    always_comb begin
        in_ready = !r_slot.v || grant;
    end

    // Refill takes priority over the grant-driven clear of the valid flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot <= '0;
        end else if (in_valid && in_ready) begin
            r_slot <= '{v: 1'b1, rd: in_rd, data: in_data};
        end else if (grant) begin
            r_slot.v <= 1'b0;
        end
    end

    assign slot = r_slot;

endmodule : wb_hold_slot
`default_nettype wire

// File: rtl/writeback_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : writeback_arbiter
// Description : Arbitrates ALU and load results onto the single register-file
//               write port. Loads win by default; after STREAK_MAX consecutive
//               load wins over a waiting ALU result, the ALU is served. Also
//               tracks outstanding loads per register (busy scoreboard).
//               Slot fields use the riscv_pkg widths, so DATA_W/ADDR_W must
//               match the package values.
// Revision    : 1.0 - initial release
// ============================================================================
module writeback_arbiter
    import riscv_pkg::wb_slot_t;
    import riscv_pkg::NUM_REGS;
#(
    parameter int DATA_W     = riscv_pkg::DATA_W,
    parameter int ADDR_W     = riscv_pkg::ADDR_W,
    parameter int STREAK_MAX = riscv_pkg::STREAK_MAX
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                alu_valid,
    output logic                alu_ready,
    input  logic [ADDR_W-1:0]   alu_rd,
    input  logic [DATA_W-1:0]   alu_data,
    input  logic                mem_valid,
    output logic                mem_ready,
    input  logic [ADDR_W-1:0]   mem_rd,
    input  logic [DATA_W-1:0]   mem_data,
    input  logic                issue_valid,
    input  logic [ADDR_W-1:0]   issue_rd,
    output logic [NUM_REGS-1:0] busy,
    output logic                we,
    output logic [ADDR_W-1:0]   ws,
    output logic [DATA_W-1:0]   wd
);

    localparam logic [1:0]          c_streak_max = 2'(STREAK_MAX);
    localparam logic [NUM_REGS-1:0] c_one_hot    = NUM_REGS'(1);

    wb_slot_t              w_alu_slot;
    wb_slot_t              w_mem_slot;
    logic                  w_grant_alu;
    logic                  w_grant_mem;
    logic [NUM_REGS-1:0]   w_busy_set;
    logic [NUM_REGS-1:0]   w_busy_clr;
    logic [1:0]            r_streak;
    logic [NUM_REGS-1:0]   r_busy;
    logic [ADDR_W-1:0]     r_ws_hold;
    logic [DATA_W-1:0]     r_wd_hold;

    wb_hold_slot u_alu_slot (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (alu_valid),
        .in_ready (alu_ready),
        .in_rd    (alu_rd),
        .in_data  (alu_data),
        .grant    (w_grant_alu),
        .slot     (w_alu_slot)
    );

    wb_hold_slot u_mem_slot (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (mem_valid),
        .in_ready (mem_ready),
        .in_rd    (mem_rd),
        .in_data  (mem_data),
        .grant    (w_grant_mem),
        .slot     (w_mem_slot)
    );

    // Grant selection and write port; driven only from slot state so the
    // write port never depends combinationally on the producer inputs.
    always_comb begin
        w_grant_mem = w_mem_slot.v && (!w_alu_slot.v || (r_streak != c_streak_max));
        w_grant_alu = w_alu_slot.v && !w_grant_mem;
        we          = w_grant_mem || w_grant_alu;
        ws          = r_ws_hold;
        wd          = r_wd_hold;
        if (w_grant_mem) begin
            ws = w_mem_slot.rd;
            wd = w_mem_slot.data;
        end else if (w_grant_alu) begin
            ws = w_alu_slot.rd;
            wd = w_alu_slot.data;
        end
        w_busy_clr = w_grant_mem ? (c_one_hot << w_mem_slot.rd) : '0;
        w_busy_set = issue_valid ? (c_one_hot << issue_rd) : '0;
    end

    // Last written select/data, so ws/wd hold steady in idle cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ws_hold <= '0;
            r_wd_hold <= '0;
        end else if (we) begin
            r_ws_hold <= ws;
            r_wd_hold <= wd;
        end
    end

    // Counts load wins while an ALU result is waiting; saturates at the cap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_streak <= '0;
        end else if (!w_alu_slot.v || w_grant_alu) begin
            r_streak <= '0;
        end else if (w_grant_mem && (r_streak != c_streak_max)) begin
            r_streak <= r_streak + 2'd1;
        end
    end

    // Pending-load scoreboard; a new issue overrides a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= (r_busy & ~w_busy_clr) | w_busy_set;
        end
    end

    assign busy = r_busy;

endmodule : writeback_arbiter
`default_nettype wire

// File: tb/tb_writeback_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_writeback_arbiter
// Description : Self-checking bench for writeback_arbiter. Accepted results
//               are queued per source; every cycle the expected write is
//               popped and compared with the DUT write port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_writeback_arbiter;

    localparam int c_streak_max = 3;

    logic        clk;
    logic        rst_n;
    logic        alu_valid;
    logic        alu_ready;
    logic [2:0]  alu_rd;
    logic [15:0] alu_data;
    logic        mem_valid;
    logic        mem_ready;
    logic [2:0]  mem_rd;
    logic [15:0] mem_data;
    logic        issue_valid;
    logic [2:0]  issue_rd;
    logic [7:0]  busy;
    logic        we;
    logic [2:0]  ws;
    logic [15:0] wd;

    writeback_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .alu_valid   (alu_valid),
        .alu_ready   (alu_ready),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .mem_valid   (mem_valid),
        .mem_ready   (mem_ready),
        .mem_rd      (mem_rd),
        .mem_data    (mem_data),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .busy        (busy),
        .we          (we),
        .ws          (ws),
        .wd          (wd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- scoreboard model ----------------
    typedef struct {
        logic [2:0]  rd;
        logic [15:0] data;
    } wr_t;

    wr_t        alu_q[$];
    wr_t        mem_q[$];
    logic [7:0] m_busy;
    int         m_streak;
    logic [2:0] m_ws;
    logic [15:0] m_wd;

    always @(negedge clk) begin : monitor
        bit  av, mv, gm, ga;
        wr_t e;
        if (!rst_n) begin
            alu_q.delete();
            mem_q.delete();
            m_busy   = '0;
            m_streak = 0;
            m_ws     = '0;
            m_wd     = '0;
            check_eq("rst_we", {31'd0, we}, 32'd0);
            check_eq("rst_busy", {24'd0, busy}, 32'd0);
        end else begin
            av = (alu_q.size() != 0);
            mv = (mem_q.size() != 0);
            gm = mv && (!av || (m_streak != c_streak_max));
            ga = av && !gm;
            check_eq("we", {31'd0, we}, {31'd0, gm || ga});
            if (gm) begin
                e = mem_q.pop_front();
                m_ws = e.rd;
                m_wd = e.data;
            end else if (ga) begin
                e = alu_q.pop_front();
                m_ws = e.rd;
                m_wd = e.data;
            end
            check_eq("ws", {29'd0, ws}, {29'd0, m_ws});
            check_eq("wd", {16'd0, wd}, {16'd0, m_wd});
            check_eq("busy", {24'd0, busy}, {24'd0, m_busy});
            check_eq("alu_ready", {31'd0, alu_ready}, {31'd0, !av || ga});
            check_eq("mem_ready", {31'd0, mem_ready}, {31'd0, !mv || gm});
            // next state after the coming rising edge
            if (!av || ga) m_streak = 0;
            else if (gm && m_streak < c_streak_max) m_streak++;
            if (alu_valid && (!av || ga)) alu_q.push_back('{rd: alu_rd, data: alu_data});
            if (mem_valid && (!mv || gm)) mem_q.push_back('{rd: mem_rd, data: mem_data});
            if (issue_valid) check_eq("issue_contract", {31'd0, m_busy[issue_rd]}, 32'd0);
            if (gm) m_busy[m_ws] = 1'b0;
            if (issue_valid) m_busy[issue_rd] = 1'b1;
        end
    end

    // Register-file image and per-register write counts from the write port.
    logic [15:0] rf[8];
    int          wr_cnt[8];
    int          wr_total = 0;
    always @(posedge clk) begin
        if (rst_n && we) begin
            rf[ws] = wd;
            wr_cnt[ws]++;
            wr_total++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin : stim
        int          snap;
        int          ai, mi, we_cnt;
        bit          af, mf;
        logic [7:0]  glog;
        for (int i = 0; i < 8; i++) begin
            rf[i] = '0;
            wr_cnt[i] = 0;
        end
        rst_n = 1'b0; alu_valid = 0; mem_valid = 0; issue_valid = 0;
        alu_rd = '0; alu_data = '0; mem_rd = '0; mem_data = '0; issue_rd = '0;
        #2;
        check_eq("reset_we", {31'd0, we}, 32'd0);
        check_eq("reset_ws", {29'd0, ws}, 32'd0);
        check_eq("reset_wd", {16'd0, wd}, 32'd0);
        check_eq("reset_busy", {24'd0, busy}, 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        #1;
        check_eq("reset_alu_ready", {31'd0, alu_ready}, 32'd1);
        check_eq("reset_mem_ready", {31'd0, mem_ready}, 32'd1);

        // ALU single write r3 = 1234
        alu_valid = 1; alu_rd = 3'd3; alu_data = 16'h1234;
        tick();
        alu_valid = 0;
        check_eq("alu_we", {31'd0, we}, 32'd1);
        check_eq("alu_ws", {29'd0, ws}, 32'd3);
        check_eq("alu_wd", {16'd0, wd}, 32'h1234);
        tick();
        check_eq("rf_r3", {16'd0, rf[3]}, 32'h1234);
        check_eq("idle_we", {31'd0, we}, 32'd0);
        check_eq("idle_ws_hold", {29'd0, ws}, 32'd3);

        // Load to r5: busy until written back
        issue_valid = 1; issue_rd = 3'd5;
        tick();
        issue_valid = 0;
        check_eq("busy5_set", {24'd0, busy}, 32'h20);
        repeat (4) tick();
        check_eq("busy5_wait", {24'd0, busy}, 32'h20);
        mem_valid = 1; mem_rd = 3'd5; mem_data = 16'hBEEF;
        tick();
        mem_valid = 0;
        check_eq("load_we", {31'd0, we}, 32'd1);
        check_eq("load_wd", {16'd0, wd}, 32'hBEEF);
        check_eq("busy5_grant", {24'd0, busy}, 32'h20);
        tick();
        check_eq("busy5_clear", {24'd0, busy}, 32'h00);

        // Dual-source saturation: expected order m,m,m,a,m,m,m,a
        ai = 0; mi = 0; we_cnt = 0; glog = '0;
        alu_valid = 1; alu_rd = 3'd0; alu_data = 16'hA000;
        mem_valid = 1; mem_rd = 3'd4; mem_data = 16'hC000;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            af = alu_valid && alu_ready;
            mf = mem_valid && mem_ready;
            if (k >= 1) begin
                we_cnt += int'(we);
                glog = {glog[6:0], ws[2]};
            end
            tick();
            if (af) begin
                ai++;
                alu_rd = {1'b0, 2'(ai)};
                alu_data = 16'hA000 + 16'(ai);
            end
            if (mf) begin
                mi++;
                mem_rd = {1'b1, 2'(mi)};
                mem_data = 16'hC000 + 16'(mi);
            end
        end
        alu_valid = 0; mem_valid = 0;
        check_eq("dual_we_count", we_cnt, 32'd8);
        check_eq("dual_grant_order", {24'd0, glog}, 32'hEE);
        repeat (4) tick();
        check_eq("dual_drained_alu", alu_q.size(), 32'd0);
        check_eq("dual_drained_mem", mem_q.size(), 32'd0);

        // Issue and grant to r2 in the same cycle: set wins
        mem_valid = 1; mem_rd = 3'd2; mem_data = 16'h2222;
        tick();
        mem_valid = 0;
        issue_valid = 1; issue_rd = 3'd2;
        check_eq("same_we", {31'd0, we}, 32'd1);
        check_eq("same_ws", {29'd0, ws}, 32'd2);
        tick();
        issue_valid = 0;
        check_eq("same_busy2", {24'd0, busy}, 32'h04);
        mem_valid = 1; mem_rd = 3'd2; mem_data = 16'h3333;
        tick();
        mem_valid = 0;
        tick();
        check_eq("busy2_clear", {24'd0, busy}, 32'h00);

        // Asynchronous reset with ALU slot full
        issue_valid = 1; issue_rd = 3'd6;
        tick();
        issue_valid = 0;
        alu_valid = 1; alu_rd = 3'd1; alu_data = 16'h0001;
        tick();
        alu_valid = 0;
        check_eq("pre_rst_we", {31'd0, we}, 32'd1);
        check_eq("pre_rst_busy", {24'd0, busy}, 32'h40);
        snap = wr_cnt[1];
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_we", {31'd0, we}, 32'd0);
        check_eq("async_busy", {24'd0, busy}, 32'd0);
        check_eq("async_ws", {29'd0, ws}, 32'd0);
        tick();
        rst_n = 1'b1;
        #1;
        check_eq("post_rst_alu_ready", {31'd0, alu_ready}, 32'd1);
        check_eq("post_rst_mem_ready", {31'd0, mem_ready}, 32'd1);
        repeat (3) tick();
        check_eq("no_r1_write", wr_cnt[1], snap);

        // ALU stream r0..r7 back to back
        snap = wr_total;
        for (int i = 0; i < 8; i++) begin
            alu_valid = 1; alu_rd = 3'(i); alu_data = 16'h00A0 + 16'(i);
            @(negedge clk);
            check_eq("stream_alu_ready", {31'd0, alu_ready}, 32'd1);
            tick();
        end
        alu_valid = 0;
        repeat (2) tick();
        check_eq("stream_writes", wr_total - snap, 32'd8);
        check_eq("rf_r7", {16'd0, rf[7]}, 32'h00A7);
        check_eq("stream_drained", alu_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule : tb_writeback_arbiter
`default_nettype wire
